// File: rtl/rr_stream_arbiter_if.sv
// rtl/rr_stream_arbiter_if.sv - producer/consumer stream bundle for rr_stream_arbiter
interface rr_stream_arbiter_if #(
  parameter int N_SRC        = 2,
  parameter int FULL_WIDTH   = 544,
  parameter int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1),
  parameter int SRC_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
  logic [N_SRC-1:0]                   in_valid;
  logic [N_SRC-1:0][FULL_WIDTH-1:0]   in_data;
  logic [N_SRC-1:0][OFFSET_WIDTH-1:0] in_len;
  logic [N_SRC-1:0]                   in_ready;

  logic                               out_valid;
  logic [FULL_WIDTH-1:0]              out_data;
  logic [OFFSET_WIDTH-1:0]            out_len;
  logic [SRC_W-1:0]                   out_src;
  logic                               out_ready;

  modport slave (
    input  in_valid, in_data, in_len, out_ready,
    output in_ready, out_valid, out_data, out_len, out_src
  );

  modport master (
    output in_valid, in_data, in_len, out_ready,
    input  in_ready, out_valid, out_data, out_len, out_src
  );
endinterface

// File: rtl/rr_stream_arbiter.sv
// rtl/rr_stream_arbiter.sv - round-robin burst arbiter merging N_SRC logging streams
module rr_stream_arbiter #(
  parameter int N_SRC        = 2,
  parameter int FULL_WIDTH   = 544,
  parameter int MAX_BURST    = 4,
  parameter int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1),
  parameter int SRC_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input logic              clk,
  input logic              rst_n,
  rr_stream_arbiter_if.slave arb
);
  typedef enum logic [0:0] {S_IDLE, S_GRANT} state_e;

  localparam logic [7:0]       LAST_BEAT = 8'(MAX_BURST - 1);
  localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(N_SRC - 1);
  localparam logic [SRC_W:0]   N_SRC_X   = (SRC_W + 1)'(N_SRC);

  state_e                  state_q, state_d;
  logic [SRC_W-1:0]        grant_q, grant_d;
  logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]              burst_cnt_q, burst_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [FULL_WIDTH-1:0]   out_data_q, out_data_d;
  logic [OFFSET_WIDTH-1:0] out_len_q, out_len_d;
  logic [SRC_W-1:0]        out_src_q, out_src_d;

  logic                    slot_free;
  logic                    accept;
  logic                    xfer;
  logic                    grant_valid;
  logic                    req_found;
  logic [SRC_W-1:0]        req_idx;
  logic [SRC_W-1:0]        grant_next;
  logic [N_SRC-1:0]        in_ready_w;

  assign slot_free   = !out_valid_q || arb.out_ready;
  assign xfer        = out_valid_q && arb.out_ready;
  assign grant_valid = arb.in_valid[grant_q];
  assign accept      = (state_q == S_GRANT) && grant_valid && slot_free;
  assign grant_next  = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;

  // First requester at or after rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    logic [SRC_W:0] idx;
    req_found = 1'b0;
    req_idx   = rr_ptr_q;
    idx       = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = {1'b0, rr_ptr_q} + (SRC_W + 1)'(i);
      if (idx >= N_SRC_X) begin
        idx = idx - N_SRC_X;
      end
      if (!req_found && arb.in_valid[idx[SRC_W-1:0]]) begin
        req_found = 1'b1;
        req_idx   = idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    in_ready_w = '0;
    if (state_q == S_GRANT) begin
      in_ready_w[grant_q] = slot_free;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;
    out_src_d   = out_src_q;

    case (state_q)
      S_IDLE: begin
        if (req_found) begin
          grant_d     = req_idx;
          burst_cnt_d = '0;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
        // A stalled but still-valid source keeps its grant; only a drained
        // source or a completed burst gives it up.
        if (!grant_valid || (accept && burst_cnt_q == LAST_BEAT)) begin
          state_d  = S_IDLE;
          rr_ptr_d = grant_next;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = arb.in_data[grant_q];
      out_len_d   = arb.in_len[grant_q];
      out_src_d   = grant_q;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
      out_src_q   <= out_src_d;
    end
  end

  assign arb.in_ready  = in_ready_w;
  assign arb.out_valid = out_valid_q;
  assign arb.out_data  = out_data_q;
  assign arb.out_len   = out_len_q;
  assign arb.out_src   = out_src_q;
endmodule

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

Round-robin scheduler that shares one record-side logging stream (valid/data/len/ready, LSB-packed logging units) between N_SRC producer streams. It sits between per-group top packers and the single storage writer. It grants one producer at a time for a bounded burst and forwards its units through a one-entry registered output slot. It tags each unit with the source index so the writer can demultiplex it.

## Interface
- N_SRC, 2, number of producer streams (2..8)
- FULL_WIDTH, 544, width of a logging unit's data field
- MAX_BURST, 4, maximum consecutive units accepted per grant (1..255)
- OFFSET_WIDTH, $clog2(FULL_WIDTH+1), derived, width of len
- SRC_W, max(1,$clog2(N_SRC)), derived
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  N_SRC  per-source unit valid
- in_data  in  N_SRC x FULL_WIDTH  per-source packed unit
- in_len  in  N_SRC x OFFSET_WIDTH  per-source valid length in bits
- in_ready  out  N_SRC  per-source accept; at most one bit high
- out_valid  out  1  output slot holds a unit
- out_data  out  FULL_WIDTH  forwarded data
- out_len  out  OFFSET_WIDTH  forwarded len
- out_src  out  SRC_W  index of the source that produced the unit
- out_ready  in  1  downstream accept

## Operation
- Reset values:
  - state IDLE; grant 0; rr_ptr 0; burst_cnt 0.
  - out_valid 0; out_data 0; out_len 0; out_src 0; in_ready all 0.
- slot_free = !out_valid || out_ready.
- A source is accepted ("accept") when in_valid[g] && in_ready[g]. An output transfer occurs when out_valid && out_ready.
- IDLE state:
  - in_ready all 0.
  - If any in_valid is high, grant <= first index i with in_valid[i], searching rr_ptr, rr_ptr+1, … wrapping modulo N_SRC. Then burst_cnt <= 0 and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT state:
  - in_ready[grant] = slot_free. All other ready bits are 0.
  - On accept: out_data/out_len <= in_data/in_len[grant]; out_src <= grant; out_valid <= 1; burst_cnt++.
  - Release the grant (go to IDLE, rr_ptr <= (grant+1) mod N_SRC) when either:
    - accept occurs with burst_cnt == MAX_BURST-1, or
    - in_valid[grant] == 0 (source drained); this check is sampled every GRANT cycle.
  - While slot_free == 0 and in_valid[grant] == 1, hold the grant. Backpressure does not count toward the burst.
- Output slot:
  - Cleared (out_valid <= 0) on an output transfer with no simultaneous accept.
  - A simultaneous transfer and accept replaces the contents. out_valid stays 1.
- len is forwarded unchecked. len == 0 units are forwarded and counted like any other unit.
- Reset mid-burst: everything returns immediately to reset values. Any unit in the slot is discarded. No partial state survives.
- Producers must hold in_valid/in_data/in_len stable until accepted. out_* holds stable while out_valid && !out_ready.

## Timing
- Arbitration latency: a request seen in IDLE at cycle t gets in_ready high at t+1 (if slot_free). The first unit appears on out_valid at t+2.
- Steady throughput is 1 unit/cycle with out_ready held high.
- Grant changeover always costs exactly one IDLE cycle with no accept, including when the same source is re-granted.
- in_ready is combinational from out_valid/out_ready/state. No other path is combinational; out_* are registered.
- Fairness: with all sources continuously valid, each source gets MAX_BURST units per round. Worst-case wait is (N_SRC-1)*(MAX_BURST+1) cycles plus downstream stall cycles.
- rr_ptr wraps from N_SRC-1 to 0.

## Test plan
- Single source, N_SRC=2, MAX_BURST=4, src0 presents 6 units (len 10..15), out_ready=1:
  - out shows 4 units, then 1 bubble cycle, then 2 units.
  - All have out_src=0, order and len preserved.
  - First out_valid is 2 cycles after the first in_valid.
- Contention: src0 and src1 both hold valid with 8 units each:
  - out_src sequence 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1, with one bubble between groups.
  - in_ready is never high on both sources.
- Backpressure: out_ready low for 5 cycles mid-burst:
  - out_data/out_len/out_src stay constant.
  - in_ready[grant] stays 0.
  - burst count is unaffected, so exactly 4 units are still delivered per grant.
- Early release: src1 drops in_valid after 2 units while src0 waits:
  - Grant passes to src0 after one IDLE cycle.
  - The next arbitration after src0 starts the search at src1.
- Wrap-around with N_SRC=3 and MAX_BURST=1, all valid:
  - out_src sequence 0,1,2,0,1,2.
  - rr_ptr returns to 0 after source 2.
- Async reset asserted mid-burst with out_valid=1:
  - out_valid and in_ready drop to 0 without waiting for a clock edge.
  - After release, the first grant goes to src0 regardless of prior rr_ptr.
